// File: rtl/dmi_uart_tx_scheduler.sv
// dmi_uart_tx_scheduler: round-robin arbiter over NUM_CH read sources that
// serialises the granted word LSB-byte-first onto the UART TX byte port.
module dmi_uart_tx_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int MAX_BITS   = 48,
    parameter int ADDRW      = 5,
    parameter int ALWAYS_HDR = 0,
    localparam int LENW      = $clog2(MAX_BITS + 1),
    localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic [NUM_CH-1:0]          CH_VALID_I,
    output logic [NUM_CH-1:0]          CH_READY_O,
    input  logic [NUM_CH*ADDRW-1:0]    CH_ADDR_I,
    input  logic [NUM_CH*MAX_BITS-1:0] CH_DATA_I,
    input  logic [NUM_CH*LENW-1:0]     CH_LEN_I,
    input  logic                       FLUSH_I,
    input  logic                       TX_READY_I,
    output logic                       WRITE_O,
    output logic [7:0]                 DATA_SEND_O,
    output logic                       SEND_COMMAND_O,
    output logic [7:0]                 COMMAND_O,
    output logic                       BUSY_O,
    output logic [GW-1:0]              GRANT_O
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam int NB = MAX_BITS / 8;
    localparam int CW = $clog2(NB + 1);

    logic [1:0]          state_q, state_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDRW-1:0]    addr_q, addr_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDRW-1:0]    last_addr_q, last_addr_d;
    logic                last_vld_q, last_vld_d;
    logic                gap_q, gap_d;
    logic                wr_q, wr_d;
    logic [7:0]          dout_q, dout_d;
    logic                cmd_q, cmd_d;
    logic [7:0]          cout_q, cout_d;

    logic                any_vld;
    logic [GW-1:0]       sel;
    logic                fire;
    logic                issue;
    logic                need_hdr;
    logic [ADDRW-1:0]    ch_addr;
    logic [MAX_BITS-1:0] ch_data;
    logic [LENW-1:0]     ch_len;
    logic [LENW-1:0]     len_eff;
    logic [MAX_BITS-1:0] mask;
    logic [CW-1:0]       nbytes;
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    int                  off;
    int                  sum;

    // Round-robin pick: rotate valids so bit 0 is rr_ptr, take lowest set.
    always_comb begin
        dbl     = {CH_VALID_I, CH_VALID_I} >> rr_q;
        rot     = dbl[NUM_CH-1:0];
        any_vld = 1'b0;
        off     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any_vld = 1'b1;
                off     = k;
            end
        end
        sum = int'(rr_q) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        sel  = GW'(sum);
        fire = (state_q == S_IDLE) && !FLUSH_I && any_vld;
    end

    // Selected channel fields, clamped length and tail mask.
    always_comb begin
        ch_addr = CH_ADDR_I[int'(sel)*ADDRW +: ADDRW];
        ch_data = CH_DATA_I[int'(sel)*MAX_BITS +: MAX_BITS];
        ch_len  = CH_LEN_I[int'(sel)*LENW +: LENW];
        len_eff = (int'(ch_len) > MAX_BITS) ? LENW'(MAX_BITS) : ch_len;
        mask    = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            mask[i] = (i < int'(len_eff));
        end
        nbytes   = CW'((int'(len_eff) + 7) / 8);
        need_hdr = (ALWAYS_HDR != 0) || !last_vld_q
                   || (ch_addr != last_addr_q);
    end

    // Accept strobe is only offered while idle and never during reset.
    always_comb begin
        CH_READY_O = '0;
        if (fire && !RST_I) begin
            CH_READY_O[sel] = 1'b1;
        end
    end

    // Frame sequencing: grant, optional header, data bytes, flush abort.
    always_comb begin
        issue = TX_READY_I && !gap_q && !FLUSH_I &&
                ((state_q == S_HDR) ||
                 ((state_q == S_DATA) && (cnt_q != '0)));
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        gap_d       = issue;
        wr_d        = 1'b0;
        dout_d      = dout_q;
        cmd_d       = 1'b0;
        cout_d      = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    addr_d  = ch_addr;
                    data_d  = ch_data & mask;
                    cnt_d   = nbytes;
                    grant_d = sel;
                    rr_d    = (int'(sel) == NUM_CH - 1) ? '0 : sel + GW'(1);
                    state_d = need_hdr ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (issue) begin
                    cmd_d       = 1'b1;
                    cout_d      = 8'(addr_q);
                    last_addr_d = addr_q;
                    last_vld_d  = 1'b1;
                    state_d     = (cnt_q == '0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else if (issue) begin
                    wr_d   = 1'b1;
                    dout_d = data_q[7:0];
                    data_d = data_q >> 8;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (FLUSH_I) begin
            state_d    = S_IDLE;
            last_vld_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            gap_q       <= 1'b0;
            wr_q        <= 1'b0;
            dout_q      <= '0;
            cmd_q       <= 1'b0;
            cout_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            gap_q       <= gap_d;
            wr_q        <= wr_d;
            dout_q      <= dout_d;
            cmd_q       <= cmd_d;
            cout_q      <= cout_d;
        end
    end

    assign WRITE_O        = wr_q;
    assign DATA_SEND_O    = dout_q;
    assign SEND_COMMAND_O = cmd_q;
    assign COMMAND_O      = cout_q;
    assign BUSY_O         = (state_q != S_IDLE);
    assign GRANT_O        = grant_q;
endmodule

// File: tb/tb_dmi_uart_tx_scheduler.sv
// tb_dmi_uart_tx_scheduler: directed scenarios plus random traffic checked
// against a frame-level byte-stream model of the scheduler.
module tb_dmi_uart_tx_scheduler;
    localparam int N  = 4;
    localparam int MB = 48;
    localparam int AW = 5;
    localparam int LW = 6;
    localparam int BIG = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ch_valid;
    logic [N-1:0]  ch_ready;
    logic [AW-1:0] a_addr [N];
    logic [MB-1:0] a_data [N];
    logic [LW-1:0] a_len  [N];
    logic [N*AW-1:0] addr_flat;
    logic [N*MB-1:0] data_flat;
    logic [N*LW-1:0] len_flat;
    logic          flush;
    logic          tx_ready;
    logic          wr_o;
    logic [7:0]    dsend;
    logic          cmd_o;
    logic [7:0]    cval;
    logic          busy_o;
    logic [1:0]    grant_o;

    logic          ah_valid;
    logic          ah_ready;
    logic [AW-1:0] ah_addr;
    logic [MB-1:0] ah_data;
    logic [LW-1:0] ah_len;
    logic          ah_wr;
    logic [7:0]    ah_dsend;
    logic          ah_cmd;
    logic [7:0]    ah_cout;
    logic          ah_busy;
    logic [0:0]    ah_grant;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        addr_flat = '0;
        data_flat = '0;
        len_flat  = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW] = a_addr[i];
            data_flat[i*MB +: MB] = a_data[i];
            len_flat[i*LW +: LW]  = a_len[i];
        end
    end

    dmi_uart_tx_scheduler #(
        .NUM_CH(N), .MAX_BITS(MB), .ADDRW(AW), .ALWAYS_HDR(0)
    ) u_dut (
        .CLK_I(clk), .RST_I(rst),
        .CH_VALID_I(ch_valid), .CH_READY_O(ch_ready),
        .CH_ADDR_I(addr_flat), .CH_DATA_I(data_flat), .CH_LEN_I(len_flat),
        .FLUSH_I(flush), .TX_READY_I(tx_ready),
        .WRITE_O(wr_o), .DATA_SEND_O(dsend),
        .SEND_COMMAND_O(cmd_o), .COMMAND_O(cval),
        .BUSY_O(busy_o), .GRANT_O(grant_o)
    );

    dmi_uart_tx_scheduler #(
        .NUM_CH(1), .MAX_BITS(MB), .ADDRW(AW), .ALWAYS_HDR(1)
    ) u_ah (
        .CLK_I(clk), .RST_I(rst),
        .CH_VALID_I(ah_valid), .CH_READY_O(ah_ready),
        .CH_ADDR_I(ah_addr), .CH_DATA_I(ah_data), .CH_LEN_I(ah_len),
        .FLUSH_I(flush), .TX_READY_I(tx_ready),
        .WRITE_O(ah_wr), .DATA_SEND_O(ah_dsend),
        .SEND_COMMAND_O(ah_cmd), .COMMAND_O(ah_cout),
        .BUSY_O(ah_busy), .GRANT_O(ah_grant)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Model state: expected byte stream {is_cmd, last_of_frame, byte}.
    logic [9:0]    exp_q [$];
    logic          m_last_vld;
    logic [AW-1:0] m_last_addr;
    int            m_rr;
    int            m_grant;
    int            busy_from;
    int            idle_from;
    int            last_strobe;
    logic          prev_txr;

    int   wr_cyc [$];
    logic [7:0] wr_val [$];
    int   hd_cyc [$];
    logic [7:0] hd_val [$];
    int   acc_ch [$];
    int   acc_n = 0;
    int   acc_cyc;
    int   busy_fall;
    logic busy_prev;

    logic [9:0]    e;
    logic [MB-1:0] md;
    logic [N-1:0]  exp_rdy;
    logic          bexp;
    int            pick;
    int            le;
    int            nb;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_last_vld  = 1'b0;
            m_last_addr = '0;
            m_rr        = 0;
            m_grant     = 0;
            busy_from   = 0;
            idle_from   = 0;
            last_strobe = -100;
            busy_prev   = 1'b0;
        end else begin
            if (wr_o) begin
                wr_cyc.push_back(cyc);
                wr_val.push_back(dsend);
            end
            if (cmd_o) begin
                hd_cyc.push_back(cyc);
                hd_val.push_back(cval);
            end
            if (wr_o || cmd_o) begin
                chk("strobe_excl", {63'd0, wr_o & cmd_o}, 0);
                chk("strobe_txr", {63'd0, prev_txr}, 1);
                chk("strobe_gap", {63'd0, (cyc - last_strobe) >= 2}, 1);
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    chk("strobe_unexp", {62'd0, wr_o, cmd_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cmd_o ? "hdr_byte" : "data_byte",
                        {55'd0, cmd_o, cmd_o ? cval : dsend},
                        {55'd0, e[9], e[7:0]});
                    if (e[8]) idle_from = e[9] ? cyc : cyc + 1;
                end
            end
            bexp = (cyc >= busy_from) && (cyc < idle_from);
            chk("busy", {63'd0, busy_o}, {63'd0, bexp});
            chk("grant", {62'd0, grant_o}, 64'(m_grant));
            if (busy_prev && !busy_o) busy_fall = cyc;
            busy_prev = busy_o;
            pick = -1;
            if (!bexp && !flush) begin
                for (int k = 0; k < N; k++) begin
                    if (ch_valid[(m_rr + k) % N]) begin
                        pick = (m_rr + k) % N;
                        break;
                    end
                end
            end
            exp_rdy = '0;
            if (pick >= 0) exp_rdy[pick] = 1'b1;
            chk("ready", {60'd0, ch_ready}, {60'd0, exp_rdy});
            if (pick >= 0) begin
                le = (int'(a_len[pick]) > MB) ? MB : int'(a_len[pick]);
                nb = (le + 7) / 8;
                md = a_data[pick];
                for (int b = 0; b < MB; b++) if (b >= le) md[b] = 1'b0;
                busy_from = cyc + 1;
                idle_from = BIG;
                if (!m_last_vld || a_addr[pick] != m_last_addr) begin
                    exp_q.push_back({1'b1, nb == 0, 8'(a_addr[pick])});
                    m_last_vld  = 1'b1;
                    m_last_addr = a_addr[pick];
                end else if (nb == 0) begin
                    idle_from = cyc + 2;
                end
                for (int k = 0; k < nb; k++) begin
                    exp_q.push_back({1'b0, k == nb - 1, md[8*k +: 8]});
                end
                m_grant = pick;
                m_rr    = (pick + 1) % N;
                acc_cyc = cyc;
                acc_ch.push_back(pick);
                acc_n++;
            end
            if (flush) begin
                exp_q.delete();
                m_last_vld = 1'b0;
                if (idle_from > cyc + 1) idle_from = cyc + 1;
            end
        end
        prev_txr = tx_ready;
    end

    int   ah_nacc, ah_ncmd, ah_nwr;
    logic [7:0] ah_lastcmd, ah_lastwr;

    always @(negedge clk) begin
        if (!rst) begin
            if (ah_valid && ah_ready) ah_nacc++;
            if (ah_cmd) begin
                ah_ncmd++;
                ah_lastcmd = ah_cout;
            end
            if (ah_wr) begin
                ah_nwr++;
                ah_lastwr = ah_dsend;
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wr_cyc.delete();
        wr_val.delete();
        hd_cyc.delete();
        hd_val.delete();
        acc_ch.delete();
    endtask

    task automatic wait_acc();
        int n0;
        int t;
        n0 = acc_n;
        for (t = 0; t < 300 && acc_n == n0; t++) step(1);
        chk("accept_wait", {63'd0, acc_n > n0}, 1);
    endtask

    task automatic wait_wr(int n);
        int t;
        for (t = 0; t < 300 && wr_cyc.size() < n; t++) step(1);
        chk("write_wait", {63'd0, wr_cyc.size() >= n}, 1);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 500 && (busy_o || exp_q.size() != 0); t++) step(1);
        chk("idle_wait", {63'd0, busy_o}, 0);
        step(2);
    endtask

    int t0;
    int s;
    int hits;
    logic [MB-1:0] bp_data;

    initial begin
        rst      = 1'b1;
        ch_valid = '0;
        flush    = 1'b0;
        tx_ready = 1'b1;
        ah_valid = 1'b0;
        ah_addr  = '0;
        ah_data  = '0;
        ah_len   = '0;
        ah_nacc  = 0;
        ah_ncmd  = 0;
        ah_nwr   = 0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0;
            a_data[i] = '0;
            a_len[i]  = '0;
        end
        step(3);
        chk("rst_write", {63'd0, wr_o}, 0);
        chk("rst_cmd", {63'd0, cmd_o}, 0);
        chk("rst_dsend", {56'd0, dsend}, 0);
        chk("rst_cval", {56'd0, cval}, 0);
        chk("rst_busy", {63'd0, busy_o}, 0);
        chk("rst_grant", {62'd0, grant_o}, 0);
        chk("rst_ready", {60'd0, ch_ready}, 0);
        rst = 1'b0;
        step(2);

        // single frame with header, latency checks
        clr_log();
        a_addr[0] = 5'h11;
        a_len[0]  = 6'd41;
        a_data[0] = 48'h01FF_FFFF_FFFF;
        ch_valid[0] = 1'b1;
        wait_acc();
        ch_valid[0] = 1'b0;
        t0 = acc_cyc;
        wait_idle();
        chk("t1_hdr_n", 64'(hd_cyc.size()), 1);
        if (hd_cyc.size() > 0) begin
            chk("t1_hdr_cyc", 64'(hd_cyc[0] - t0), 2);
            chk("t1_hdr_val", {56'd0, hd_val[0]}, 8'h11);
        end
        chk("t1_wr_n", 64'(wr_cyc.size()), 6);
        for (int k = 0; k < 6 && k < wr_cyc.size(); k++) begin
            chk("t1_wr_cyc", 64'(wr_cyc[k] - t0), 64'(4 + 2 * k));
            chk("t1_wr_val", {56'd0, wr_val[k]}, (k == 5) ? 8'h01 : 8'hFF);
        end
        chk("t1_busy_fall", 64'(busy_fall - t0), 15);

        // same address: header suppressed
        clr_log();
        a_len[0]  = 6'd8;
        a_data[0] = 48'hA5;
        ch_valid[0] = 1'b1;
        wait_acc();
        ch_valid[0] = 1'b0;
        t0 = acc_cyc;
        wait_idle();
        chk("t2_hdr_n", 64'(hd_cyc.size()), 0);
        chk("t2_wr_n", 64'(wr_cyc.size()), 1);
        if (wr_cyc.size() > 0) begin
            chk("t2_wr_cyc", 64'(wr_cyc[0] - t0), 2);
            chk("t2_wr_val", {56'd0, wr_val[0]}, 8'hA5);
        end

        // header on every frame when forced
        ah_addr  = 5'h11;
        ah_len   = 6'd8;
        ah_data  = 48'hA5;
        ah_nacc  = 0;
        ah_ncmd  = 0;
        ah_nwr   = 0;
        ah_valid = 1'b1;
        for (int t = 0; t < 200 && ah_nacc < 2; t++) step(1);
        ah_valid = 1'b0;
        step(12);
        chk("ah_acc", 64'(ah_nacc), 2);
        chk("ah_hdr_n", 64'(ah_ncmd), 2);
        chk("ah_wr_n", 64'(ah_nwr), 2);
        chk("ah_hdr_val", {56'd0, ah_lastcmd}, 8'h11);
        chk("ah_wr_val", {56'd0, ah_lastwr}, 8'hA5);

        // round robin from reset, all channels valid
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        clr_log();
        for (int i = 0; i < N; i++) begin
            a_addr[i] = AW'(i + 1);
            a_len[i]  = 6'd8;
            a_data[i] = 48'(8'h30 + i);
        end
        ch_valid = '1;
        for (int t = 0; t < 400 && acc_ch.size() < 5; t++) step(1);
        ch_valid = '0;
        wait_idle();
        chk("t3_acc_n", 64'(acc_ch.size()), 5);
        for (int k = 0; k < 5 && k < acc_ch.size(); k++) begin
            chk("t3_order", 64'(acc_ch[k]), 64'(k % N));
        end
        chk("t3_hdr_n", 64'(hd_cyc.size()), 5);

        // backpressure for 5 cycles mid-frame
        clr_log();
        bp_data = 48'h6655_4433_2211;
        a_addr[2] = 5'h05;
        a_len[2]  = 6'd48;
        a_data[2] = bp_data;
        ch_valid[2] = 1'b1;
        wait_acc();
        ch_valid[2] = 1'b0;
        wait_wr(2);
        tx_ready = 1'b0;
        s = cyc;
        step(5);
        tx_ready = 1'b1;
        wait_idle();
        hits = 0;
        foreach (wr_cyc[k]) if (wr_cyc[k] > s && wr_cyc[k] <= s + 5) hits++;
        chk("t4_stall_quiet", 64'(hits), 0);
        chk("t4_wr_n", 64'(wr_cyc.size()), 6);
        for (int k = 0; k < 6 && k < wr_val.size(); k++) begin
            chk("t4_wr_val", {56'd0, wr_val[k]}, {56'd0, bp_data[8*k +: 8]});
        end

        // flush after two data bytes
        clr_log();
        a_addr[3] = 5'h07;
        a_len[3]  = 6'd48;
        a_data[3] = {$urandom, $urandom};
        ch_valid[3] = 1'b1;
        wait_acc();
        ch_valid[3] = 1'b0;
        wait_wr(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t5_busy_after", {63'd0, busy_o}, 0);
        step(12);
        chk("t5_wr_n", 64'(wr_cyc.size()), 2);
        clr_log();
        a_len[3] = 6'd8;
        ch_valid[3] = 1'b1;
        wait_acc();
        ch_valid[3] = 1'b0;
        wait_idle();
        chk("t5_rehdr_n", 64'(hd_cyc.size()), 1);
        if (hd_cyc.size() > 0) chk("t5_rehdr_val", {56'd0, hd_val[0]}, 8'h07);

        // asynchronous reset during data
        clr_log();
        a_addr[1] = 5'h09;
        a_len[1]  = 6'd48;
        a_data[1] = {$urandom, $urandom} | 48'hFF;
        ch_valid[1] = 1'b1;
        wait_acc();
        wait_wr(1);
        #2 rst = 1'b1;
        #1;
        chk("t6_write", {63'd0, wr_o}, 0);
        chk("t6_cmd", {63'd0, cmd_o}, 0);
        chk("t6_dsend", {56'd0, dsend}, 0);
        chk("t6_cval", {56'd0, cval}, 0);
        chk("t6_busy", {63'd0, busy_o}, 0);
        chk("t6_grant", {62'd0, grant_o}, 0);
        chk("t6_ready", {60'd0, ch_ready}, 0);
        clr_log();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_acc();
        ch_valid[1] = 1'b0;
        wait_idle();
        chk("t6_hdr_n", 64'(hd_cyc.size()), 1);
        if (hd_cyc.size() > 0) chk("t6_hdr_val", {56'd0, hd_val[0]}, 8'h09);

        // random traffic against the model
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!ch_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a_addr[i] = ($urandom_range(0, 3) == 0) ?
                                    AW'($urandom) : AW'($urandom_range(0, 3));
                        a_data[i] = {$urandom, $urandom};
                        a_len[i]  = LW'($urandom_range(0, 63));
                        ch_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    ch_valid[i] = 1'b0;
                end
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 149) == 0);
            step(1);
        end
        ch_valid = '0;
        flush    = 1'b0;
        tx_ready = 1'b1;
        wait_idle();
        chk("drain_q", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmi_uart_tx_scheduler.md
# dmi_uart_tx_scheduler

Multi-channel successor to the single-register read path of the UART debug TAP. It arbitrates up to NUM_CH read sources with a round-robin policy and serialises the granted word LSB-byte-first onto the UART TX byte interface. When the target address changes, it prefixes the data with an address command byte, so the host always knows which register the following bytes belong to. It sits between the DMI/DTM register read ports and the UART transmitter, replacing the per-address ready/valid read logic of the TAP.

## Interface
Parameters:
- NUM_CH, 4: number of read channels; 1..16.
- MAX_BITS, 48: data width per channel; multiple of 8.
- ADDRW, 5: address width; ≤8. The header byte is the address zero-extended to 8 bits.
- ALWAYS_HDR, 0: 1 = send the header before every frame; 0 = send it only when the address differs from the last header sent.
- LENW (local): $clog2(MAX_BITS+1).

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- CH_VALID_I  in  NUM_CH  per-channel data valid.
- CH_READY_O  out  NUM_CH  one-hot accept; combinational.
- CH_ADDR_I  in  NUM_CH*ADDRW  per-channel address; channel i occupies slice i.
- CH_DATA_I  in  NUM_CH*MAX_BITS  per-channel data.
- CH_LEN_I  in  NUM_CH*LENW  per-channel valid bit count.
- FLUSH_I  in  1  abort the current frame and invalidate the last-address memory.
- TX_READY_I  in  1  UART TX can take a byte.
- WRITE_O  out  1  one-cycle data byte strobe.
- DATA_SEND_O  out  8  data byte.
- SEND_COMMAND_O  out  1  one-cycle command byte strobe.
- COMMAND_O  out  8  command (header) byte.
- BUSY_O  out  1  high in any state other than IDLE.
- GRANT_O  out  $clog2(NUM_CH) (min 1)  index of the channel currently or last served.

## Operation
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If FLUSH_I is low and any CH_VALID_I is high, select the first valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  - CH_READY_O[sel] = 1 in that cycle only; that cycle is the handshake.
  - On the clock edge: latch addr, data and len; set GRANT_O=sel; set rr_ptr=(sel+1) mod NUM_CH.
  - Go to HDR if ALWAYS_HDR, or last_vld=0, or addr≠last_addr. Otherwise go to DATA.
- Byte issue rule, shared by HDR and DATA: a byte issues in a cycle where TX_READY_I=1 and gap=0. The strobe and byte are registered and appear the next cycle for exactly one cycle. gap is set for one cycle after each issue, giving a minimum of 2 cycles per byte.
- HDR: issue SEND_COMMAND_O with COMMAND_O={zero-ext, addr}. Then set last_addr=addr and last_vld=1. Go to DATA, or to IDLE if the byte count is 0.
- DATA:
  - byte count = ceil(len_eff/8), where len_eff = min(len, MAX_BITS).
  - Issue bytes k=0..count-1 with DATA_SEND_O = data[8k+7:8k].
  - In the final byte, bits at positions ≥ len_eff are forced to 0.
  - After the last issue, go to IDLE.
- len=0 with no header required: the frame completes with no TX activity. The FSM returns to IDLE the next cycle.
- FLUSH_I, sampled in any state:
  - Next state is IDLE and last_vld=0.
  - A strobe already registered still completes; no further bytes issue.
  - No grant is given in a cycle where FLUSH_I=1.
- CH_VALID_I dropping before a grant is legal. The channel is simply not selected.

## Timing
- Reset values:
  - CH_READY_O=0, WRITE_O=0, SEND_COMMAND_O=0, DATA_SEND_O=0, COMMAND_O=0.
  - BUSY_O=0, GRANT_O=0, rr_ptr=0, last_vld=0, gap=0, state IDLE.
- Reset mid-frame: all outputs drop asynchronously. Latched data is discarded and nothing resumes.
- Latency with TX_READY_I held high:
  - Accept at cycle 0.
  - Header strobe at cycle 2.
  - First data strobe at cycle 4.
  - Each subsequent data strobe 2 cycles later.
  - Without a header, the first data strobe is at cycle 2.
- Back-to-back frames: the next grant can occur in the cycle after the last byte's strobe.
- TX_READY_I low stalls in place; byte index and state are held.
- Simultaneous valids: only one grant per IDLE cycle. Fairness: any continuously valid channel is served within NUM_CH frames.

## Test plan
- Single frame: ch0 addr=0x11, len=41, data=0x1FF_FFFF_FFFF, TX_READY_I=1 → COMMAND_O=0x11 at cycle 2; bytes FF,FF,FF,FF,FF,01 at cycles 4,6,8,10,12,14; BUSY_O falls at cycle 15.
- Header suppression: a second ch0 frame with the same addr=0x11, len=8, data=0xA5 → no SEND_COMMAND_O; WRITE_O with 0xA5 at cycle 2. Same test with ALWAYS_HDR=1 → header is resent.
- Round robin: NUM_CH=4, all valid continuously, distinct addrs → grant order 0,1,2,3,0. Each frame is preceded by a header.
- Backpressure: TX_READY_I low for 5 cycles mid-frame → no strobes during the stall; byte order is unchanged; no byte is duplicated or lost.
- Flush mid-frame after 2 of 6 data bytes → no further WRITE_O; BUSY_O=0 the next cycle. A following same-address frame re-emits the header.
- Reset asserted asynchronously during DATA → all outputs 0 immediately. After release, a frame to the previous address sends a header (last_vld=0).
